echo_ind_marshal: RTL and testbench

- Downstream stage of the echo server. It consumes the ind_echo indication method calls and buffers their payloads in a small FIFO.
- Each payload is serialized onto the host indication pipe as a 2-word frame: a header word, then the payload word.
- It decouples echo's rule_respond from host-side backpressure. It exports ind_echo__RDY so that rule_respond fires only when buffer space exists.

---
 rtl/echo_ind_marshal_if.sv | 19 +
 rtl/echo_ind_marshal.sv | 67 ++++++
 tb/tb_echo_ind_marshal.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/echo_ind_marshal_if.sv
// echo_ind_marshal_if: indication call side and host pipe side of the echo marshaller
interface echo_ind_marshal_if;
   logic        ind_echo__ENA;
   logic [31:0] ind_echo_v;
   logic        ind_echo__RDY;
   logic        pipe_enq__ENA;
   logic [31:0] pipe_enq_v;
   logic        pipe_enq__RDY;
   logic [31:0] frames_sent;
   logic        busy;
   modport master (
      output ind_echo__ENA, ind_echo_v, pipe_enq__RDY,
      input  ind_echo__RDY, pipe_enq__ENA, pipe_enq_v, frames_sent, busy
   );
   modport slave (
      input  ind_echo__ENA, ind_echo_v, pipe_enq__RDY,
      output ind_echo__RDY, pipe_enq__ENA, pipe_enq_v, frames_sent, busy
   );
endinterface

// File: rtl/echo_ind_marshal.sv
// echo_ind_marshal: buffers ind_echo payloads and serializes each as a header + payload frame
module echo_ind_marshal #(
   parameter int          DEPTH     = 4,
   parameter logic [15:0] METHOD_ID = 16'h0001
) (
   input logic               CLK,
   input logic               nRST,
   echo_ind_marshal_if.slave b
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);
   typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
   state_t        state, state_n;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic [31:0]   frames_q, word;
   logic          push, pop, ena;
   // full/empty come from count, so pointer equality never has to be disambiguated
   assign push            = b.ind_echo__ENA && count != FULL;
   assign pop             = state == PAY && b.pipe_enq__RDY;
   assign b.ind_echo__RDY = nRST || count != FULL;
   assign b.pipe_enq__ENA = ena && !nRST;
   assign b.pipe_enq_v    = nRST ? '0 : word;
   assign b.frames_sent   = frames_q;
   assign b.busy          = !nRST && (state != IDLE || count != '0);
   always_comb begin
      state_n = state;
      ena     = 1'b0;
      word    = '0;
      case (state)
         IDLE: state_n = count != '0 ? HDR : IDLE;
         HDR: begin
            ena     = 1'b1;
            word    = {METHOD_ID, 16'd2};
            state_n = b.pipe_enq__RDY ? PAY : HDR;
         end
         PAY: begin
            ena     = 1'b1;
            word    = mem[rd_ptr];
            state_n = !b.pipe_enq__RDY ? PAY : (count > ONE || push) ? HDR : IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (nRST) begin
         state    <= IDLE;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         frames_q <= '0;
      end else begin
         state <= state_n;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            frames_q <= frames_q + 32'd1;
         end
      end
   end
   always_ff @(posedge CLK) begin
      if (push && !nRST) mem[wr_ptr] <= b.ind_echo_v;
   end
endmodule

// File: tb/tb_echo_ind_marshal.sv
// tb_echo_ind_marshal: vector table, directed corner sequences and a randomized scoreboard run
module tb_echo_ind_marshal;
   localparam int          DEPTH = 4;
   localparam int          NF    = DEPTH * 3 + 1;
   localparam logic [31:0] HDR_W = 32'h0001_0002;

   logic CLK = 1'b0;
   logic nRST;
   int   checks = 0;
   int   errors = 0;

   echo_ind_marshal_if bus ();
   echo_ind_marshal #(.DEPTH(DEPTH), .METHOD_ID(16'h0001)) dut (.CLK(CLK), .nRST(nRST), .b(bus));

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst, ena;
      logic [31:0] v;
      logic        prdy, e_rdy, e_ena;
      logic [31:0] e_v;
      logic        e_busy;
      logic [31:0] e_frames;
   } vec_t;
   vec_t vt [20];

   function automatic vec_t mk(input logic r, e, input logic [31:0] v, input logic p, er, ee,
                               input logic [31:0] ev, input logic eb, input logic [31:0] ef);
      vec_t x;
      x.rst = r; x.ena = e; x.v = v; x.prdy = p; x.e_rdy = er; x.e_ena = ee;
      x.e_v = ev; x.e_busy = eb; x.e_frames = ef;
      return x;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", n, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drv(input logic r, e, input logic [31:0] v, input logic p);
      nRST              = r;
      bus.ind_echo__ENA = e;
      bus.ind_echo_v    = v;
      bus.pipe_enq__RDY = p;
      #1;
   endtask

   task automatic send1(input logic [31:0] v);
      drv(0, 1, v, 1);
      tick();
      repeat (3) begin
         drv(0, 0, 0, 1);
         tick();
      end
   endtask

   logic [31:0] wq [$];
   logic [31:0] nd, fexp, pv;
   logic        e, p, full, pe, pp;
   int          pushed;

   initial begin
      // single call, reset with an ignored call, then fill under backpressure and drain
      vt[0]  = mk(0, 1, 32'hDEADBEEF, 1, 1, 0, 0,            0, 0);
      vt[1]  = mk(0, 0, 0,            1, 1, 0, 0,            1, 0);
      vt[2]  = mk(0, 0, 0,            1, 1, 1, HDR_W,        1, 0);
      vt[3]  = mk(0, 0, 0,            1, 1, 1, 32'hDEADBEEF, 1, 0);
      vt[4]  = mk(0, 0, 0,            1, 1, 0, 0,            0, 1);
      vt[5]  = mk(1, 1, 32'h99,       1, 1, 0, 0,            0, 1);
      vt[6]  = mk(0, 1, 1,            0, 1, 0, 0,            0, 0);
      vt[7]  = mk(0, 1, 2,            0, 1, 0, 0,            1, 0);
      vt[8]  = mk(0, 1, 3,            0, 1, 1, HDR_W,        1, 0);
      vt[9]  = mk(0, 1, 4,            0, 1, 1, HDR_W,        1, 0);
      vt[10] = mk(0, 1, 5,            0, 0, 1, HDR_W,        1, 0);
      vt[11] = mk(0, 0, 0,            1, 0, 1, HDR_W,        1, 0);
      vt[12] = mk(0, 0, 0,            1, 0, 1, 1,            1, 0);
      vt[13] = mk(0, 0, 0,            1, 1, 1, HDR_W,        1, 1);
      vt[14] = mk(0, 0, 0,            1, 1, 1, 2,            1, 1);
      vt[15] = mk(0, 0, 0,            1, 1, 1, HDR_W,        1, 2);
      vt[16] = mk(0, 0, 0,            1, 1, 1, 3,            1, 2);
      vt[17] = mk(0, 0, 0,            1, 1, 1, HDR_W,        1, 3);
      vt[18] = mk(0, 0, 0,            1, 1, 1, 4,            1, 3);
      vt[19] = mk(0, 0, 0,            1, 1, 0, 0,            0, 4);

      drv(1, 0, 0, 0);
      tick();
      tick();
      drv(0, 0, 0, 0);
      chk("rst_rdy", bus.ind_echo__RDY, 1);
      chk("rst_ena", bus.pipe_enq__ENA, 0);
      chk("rst_v", bus.pipe_enq_v, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_frames", bus.frames_sent, 0);
      tick();

      for (int i = 0; i < 20; i++) begin
         drv(vt[i].rst, vt[i].ena, vt[i].v, vt[i].prdy);
         chk($sformatf("vec%0d_rdy", i), bus.ind_echo__RDY, vt[i].e_rdy);
         chk($sformatf("vec%0d_ena", i), bus.pipe_enq__ENA, vt[i].e_ena);
         chk($sformatf("vec%0d_v", i), bus.pipe_enq_v, vt[i].e_v);
         chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].e_busy);
         chk($sformatf("vec%0d_frames", i), bus.frames_sent, vt[i].e_frames);
         tick();
      end

      // a new call lands in the same cycle the last queued payload leaves
      drv(0, 1, 32'h11, 1); tick();
      drv(0, 0, 0, 1);      tick();
      drv(0, 0, 0, 1);      chk("cc_hdr", bus.pipe_enq_v, HDR_W); tick();
      drv(0, 1, 32'h77, 1); chk("cc_pay0", bus.pipe_enq_v, 32'h11); chk("cc_rdy", bus.ind_echo__RDY, 1); tick();
      drv(0, 0, 0, 1);      chk("cc_hdr2_ena", bus.pipe_enq__ENA, 1); chk("cc_hdr2", bus.pipe_enq_v, HDR_W); tick();
      drv(0, 0, 0, 1);      chk("cc_pay1", bus.pipe_enq_v, 32'h77); tick();
      drv(0, 0, 0, 1);      chk("cc_idle_busy", bus.busy, 0); chk("cc_frames", bus.frames_sent, 6); tick();

      // payload held through two stall cycles
      drv(0, 1, 32'hA5A5A5A5, 0); tick();
      drv(0, 0, 0, 0); tick();
      drv(0, 0, 0, 1); chk("st_hdr", bus.pipe_enq_v, HDR_W); tick();
      drv(0, 0, 0, 0); chk("st_pay_a", bus.pipe_enq_v, 32'hA5A5A5A5); tick();
      drv(0, 0, 0, 0); chk("st_pay_b_ena", bus.pipe_enq__ENA, 1); chk("st_pay_b", bus.pipe_enq_v, 32'hA5A5A5A5); tick();
      drv(0, 0, 0, 1); chk("st_pay_c", bus.pipe_enq_v, 32'hA5A5A5A5); chk("st_frames_pre", bus.frames_sent, 6); tick();
      drv(0, 0, 0, 0); chk("st_done_ena", bus.pipe_enq__ENA, 0); chk("st_frames", bus.frames_sent, 7); tick();

      // reset while a payload is on the pipe with three entries queued
      drv(0, 1, 1, 0); tick();
      drv(0, 1, 2, 0); tick();
      drv(0, 1, 3, 0); tick();
      drv(0, 0, 0, 1); chk("rm_hdr", bus.pipe_enq_v, HDR_W); tick();
      drv(0, 0, 0, 0); chk("rm_pay", bus.pipe_enq_v, 1); tick();
      drv(1, 1, 9, 1); chk("rm_during_ena", bus.pipe_enq__ENA, 0); chk("rm_during_rdy", bus.ind_echo__RDY, 1); tick();
      drv(0, 0, 0, 1);
      chk("rm_ena", bus.pipe_enq__ENA, 0);
      chk("rm_rdy", bus.ind_echo__RDY, 1);
      chk("rm_frames", bus.frames_sent, 0);
      chk("rm_busy", bus.busy, 0);
      tick();
      for (int i = 0; i < 6; i++) begin
         drv(0, 0, 0, 1);
         chk($sformatf("rm_quiet%0d", i), bus.pipe_enq__ENA, 0);
         tick();
      end

      // frame counter wrap
      force dut.frames_q = 32'hFFFF_FFFF;
      tick();
      release dut.frames_q;
      drv(0, 0, 0, 1);
      chk("wr_start", bus.frames_sent, 32'hFFFF_FFFF);
      send1(32'hC1);
      drv(0, 0, 0, 1); chk("wr_zero", bus.frames_sent, 0);
      send1(32'hC2);
      drv(0, 0, 0, 1); chk("wr_one", bus.frames_sent, 1);
      tick();

      // randomized traffic against a word-stream scoreboard
      drv(1, 0, 0, 0);
      tick();
      nd = 32'h100; fexp = 0; pushed = 0; pe = 0; pp = 0; pv = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (pushed >= NF && wq.size() == 0) break;
         e = pushed < NF && $urandom_range(0, 3) != 0;
         p = $urandom_range(0, 2) != 0;
         drv(0, e, nd, p);
         full = (wq.size() + 1) / 2 >= DEPTH;
         chk("rnd_rdy", bus.ind_echo__RDY, !full);
         chk("rnd_frames", bus.frames_sent, fexp);
         if (pe && !pp) begin
            chk("rnd_hold_ena", bus.pipe_enq__ENA, 1);
            chk("rnd_hold_v", bus.pipe_enq_v, pv);
         end
         if (bus.pipe_enq__ENA) begin
            if (wq.size() == 0) chk("rnd_spurious_ena", bus.pipe_enq__ENA, 0);
            else chk("rnd_word", bus.pipe_enq_v, wq[0]);
         end
         if (bus.pipe_enq__ENA && p && wq.size() != 0) begin
            if (wq.size() % 2 == 1) fexp++;
            void'(wq.pop_front());
         end
         if (e && !full) begin
            wq.push_back(HDR_W);
            wq.push_back(nd);
            nd++;
            pushed++;
         end
         pe = bus.pipe_enq__ENA;
         pp = p;
         pv = bus.pipe_enq_v;
         tick();
      end
      chk("rnd_drained", wq.size(), 0);
      drv(0, 0, 0, 0);
      chk("rnd_frames_end", bus.frames_sent, NF);
      chk("rnd_busy_end", bus.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
